// File: rtl/vga_pixel_arbiter.sv
// vga_pixel_arbiter
// Sits between a circle drawer and a VGA adapter. Drawer pixels pass through
// with one cycle of latency. Off-screen pixels are clipped and counted. A
// clear request takes the output path for a full-screen row-major sweep in a
// single colour, then reports completion with a one-cycle DONE pulse.
// Optional macro PIX_DEDUP_EN: when defined, an in-range pixel identical to
// the last one forwarded is suppressed.
module vga_pixel_arbiter #(
    parameter int H_RES = 160,
    parameter int V_RES = 120
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear_req,
    input  logic [2:0] clear_colour,
    input  logic       in_plot,
    input  logic [7:0] in_x,
    input  logic [6:0] in_y,
    input  logic [2:0] in_colour,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    output logic       busy,
    output logic       clear_done,
    output logic [7:0] clip_cnt,
    output logic       dropped
);

    typedef enum logic [1:0] {
        ST_PASS  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Limits widened by one bit so a 256-wide or 128-high screen still compares.
    localparam logic [8:0] X_LIM  = 9'(H_RES);
    localparam logic [7:0] Y_LIM  = 8'(V_RES);
    localparam logic [7:0] X_LAST = 8'(H_RES - 1);
    localparam logic [6:0] Y_LAST = 7'(V_RES - 1);

    state_t     state_r, state_next_s;
    logic [7:0] vga_x_r, vga_x_next_s;
    logic [6:0] vga_y_r, vga_y_next_s;
    logic [2:0] vga_colour_r, vga_colour_next_s;
    logic       vga_plot_r, vga_plot_next_s;
    logic       busy_r, busy_next_s;
    logic       clear_done_r, clear_done_next_s;
    logic [7:0] clip_cnt_r, clip_cnt_next_s;
    logic       dropped_r, dropped_next_s;
    logic [7:0] sweep_x_r, sweep_x_next_s;
    logic [6:0] sweep_y_r, sweep_y_next_s;
    logic       in_range_s;

`ifdef PIX_DEDUP_EN
    logic       last_valid_r, last_valid_next_s;
    logic [7:0] last_x_r, last_x_next_s;
    logic [6:0] last_y_r, last_y_next_s;
    logic [2:0] last_colour_r, last_colour_next_s;
    logic       dup_s;

    assign dup_s = last_valid_r && (in_x == last_x_r) && (in_y == last_y_r)
                   && (in_colour == last_colour_r);
`endif

    assign in_range_s = ({1'b0, in_x} < X_LIM) && ({1'b0, in_y} < Y_LIM);

    assign vga_x      = vga_x_r;
    assign vga_y      = vga_y_r;
    assign vga_colour = vga_colour_r;
    assign vga_plot   = vga_plot_r;
    assign busy       = busy_r;
    assign clear_done = clear_done_r;
    assign clip_cnt   = clip_cnt_r;
    assign dropped    = dropped_r;

    // Next-state and next-output decode; every output is registered from these.
    always_comb begin
        state_next_s      = state_r;
        vga_x_next_s      = vga_x_r;
        vga_y_next_s      = vga_y_r;
        vga_colour_next_s = vga_colour_r;
        vga_plot_next_s   = 1'b0;
        busy_next_s       = 1'b0;
        clear_done_next_s = 1'b0;
        clip_cnt_next_s   = clip_cnt_r;
        dropped_next_s    = dropped_r;
        sweep_x_next_s    = sweep_x_r;
        sweep_y_next_s    = sweep_y_r;
`ifdef PIX_DEDUP_EN
        last_valid_next_s  = last_valid_r;
        last_x_next_s      = last_x_r;
        last_y_next_s      = last_y_r;
        last_colour_next_s = last_colour_r;
`endif
        case (state_r)
            ST_PASS: begin
                if (clear_req) begin
                    // Clear wins; a simultaneous drawer pixel is lost.
                    state_next_s      = ST_CLEAR;
                    sweep_x_next_s    = 8'd0;
                    sweep_y_next_s    = 7'd0;
                    vga_x_next_s      = 8'd0;
                    vga_y_next_s      = 7'd0;
                    vga_colour_next_s = clear_colour;
                    vga_plot_next_s   = 1'b1;
                    busy_next_s       = 1'b1;
                    dropped_next_s    = dropped_r | in_plot;
`ifdef PIX_DEDUP_EN
                    last_valid_next_s = 1'b0;
`endif
                end else if (in_plot && in_range_s) begin
`ifdef PIX_DEDUP_EN
                    if (dup_s) begin
                        vga_plot_next_s = 1'b0;
                    end else begin
                        vga_x_next_s       = in_x;
                        vga_y_next_s       = in_y;
                        vga_colour_next_s  = in_colour;
                        vga_plot_next_s    = 1'b1;
                        last_valid_next_s  = 1'b1;
                        last_x_next_s      = in_x;
                        last_y_next_s      = in_y;
                        last_colour_next_s = in_colour;
                    end
`else
                    vga_x_next_s      = in_x;
                    vga_y_next_s      = in_y;
                    vga_colour_next_s = in_colour;
                    vga_plot_next_s   = 1'b1;
`endif
                end else if (in_plot) begin
                    clip_cnt_next_s = (clip_cnt_r == 8'hFF) ? 8'hFF : clip_cnt_r + 8'd1;
                end else begin
                    state_next_s = ST_PASS;
                end
            end
            ST_CLEAR: begin
                // Drawer pixels are discarded and clear requests ignored while sweeping.
                dropped_next_s = dropped_r | in_plot;
                if ((sweep_x_r == X_LAST) && (sweep_y_r == Y_LAST)) begin
                    state_next_s      = ST_DONE;
                    clear_done_next_s = 1'b1;
                end else if (sweep_x_r == X_LAST) begin
                    sweep_x_next_s  = 8'd0;
                    sweep_y_next_s  = sweep_y_r + 7'd1;
                    vga_x_next_s    = 8'd0;
                    vga_y_next_s    = sweep_y_r + 7'd1;
                    vga_plot_next_s = 1'b1;
                    busy_next_s     = 1'b1;
                end else begin
                    sweep_x_next_s  = sweep_x_r + 8'd1;
                    vga_x_next_s    = sweep_x_r + 8'd1;
                    vga_plot_next_s = 1'b1;
                    busy_next_s     = 1'b1;
                end
            end
            ST_DONE: begin
                dropped_next_s = dropped_r | in_plot;
                state_next_s   = ST_PASS;
            end
            default: begin
                state_next_s = ST_PASS;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_PASS;
            vga_x_r      <= 8'd0;
            vga_y_r      <= 7'd0;
            vga_colour_r <= 3'd0;
            vga_plot_r   <= 1'b0;
            busy_r       <= 1'b0;
            clear_done_r <= 1'b0;
            clip_cnt_r   <= 8'd0;
            dropped_r    <= 1'b0;
            sweep_x_r    <= 8'd0;
            sweep_y_r    <= 7'd0;
        end else begin
            state_r      <= state_next_s;
            vga_x_r      <= vga_x_next_s;
            vga_y_r      <= vga_y_next_s;
            vga_colour_r <= vga_colour_next_s;
            vga_plot_r   <= vga_plot_next_s;
            busy_r       <= busy_next_s;
            clear_done_r <= clear_done_next_s;
            clip_cnt_r   <= clip_cnt_next_s;
            dropped_r    <= dropped_next_s;
            sweep_x_r    <= sweep_x_next_s;
            sweep_y_r    <= sweep_y_next_s;
        end
    end

`ifdef PIX_DEDUP_EN
    // Last-forwarded-pixel record used to suppress repeats.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_valid_r  <= 1'b0;
            last_x_r      <= 8'd0;
            last_y_r      <= 7'd0;
            last_colour_r <= 3'd0;
        end else begin
            last_valid_r  <= last_valid_next_s;
            last_x_r      <= last_x_next_s;
            last_y_r      <= last_y_next_s;
            last_colour_r <= last_colour_next_s;
        end
    end
`endif

endmodule
